// File: rtl/ddr_frame_writer.sv
// Packs 24-bit pixels from the clock-crossing FIFO into 128-bit DDR2 words and
// writes them to the MIG at consecutive addresses; flags end_of_write when the frame is stored.
module ddr_frame_writer #(
  parameter int unsigned PIXEL_W      = 24,
  parameter int unsigned PIX_PER_WORD = 5,
  parameter int unsigned DATA_W       = 128,
  parameter int unsigned ADDR_W       = 27,
  parameter int unsigned ADDR_STEP    = 8,
  parameter int unsigned BASE_ADDR    = 0,
  parameter int unsigned FRAME_PIXELS = 786432
) (
  input  logic               clk,
  input  logic               cpu_resetn,
  input  logic               init_calib_complete,
  input  logic               fifo_empty,
  output logic               fifo_rd_en,
  input  logic [PIXEL_W-1:0] fifo_dout,
  input  logic               fifo_valid,
  output logic [ADDR_W-1:0]  app_addr,
  output logic [2:0]         app_cmd,
  output logic               app_en,
  input  logic               app_rdy,
  output logic [DATA_W-1:0]  app_wdf_data,
  output logic               app_wdf_wren,
  output logic               app_wdf_end,
  output logic [15:0]        app_wdf_mask,
  input  logic               app_wdf_rdy,
  output logic               busy_write,
  output logic               end_of_write
);

  localparam int unsigned WORDS     = (FRAME_PIXELS + PIX_PER_WORD - 1) / PIX_PER_WORD;
  localparam int unsigned WC_W      = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned CNT_W     = $clog2(PIX_PER_WORD + 1);
  localparam int unsigned LAST_NEED = FRAME_PIXELS - PIX_PER_WORD * (WORDS - 1);

  typedef enum logic [1:0] {WAIT_CALIB, FILL, ISSUE, DONE} state_t;

  state_t            state;
  logic [WC_W-1:0]   word_cnt;
  logic [CNT_W-1:0]  req_cnt;
  logic [CNT_W-1:0]  cap_cnt;
  logic [CNT_W-1:0]  need_c;
  logic              last_word_c;
  logic              cmd_ok_c;
  logic              dat_ok_c;

  assign last_word_c = (word_cnt == WC_W'(WORDS - 1));
  assign need_c      = last_word_c ? CNT_W'(LAST_NEED) : CNT_W'(PIX_PER_WORD);

  // Read request is combinational so a pop never follows a stale empty flag.
  assign fifo_rd_en  = (state == FILL) && !fifo_empty && (req_cnt < need_c);

  // A handshake counts as done once its strobe has already dropped.
  assign cmd_ok_c    = !app_en || app_rdy;
  assign dat_ok_c    = !app_wdf_wren || app_wdf_rdy;

  assign app_cmd      = 3'b000;
  assign app_wdf_mask = 16'h0000;
  assign app_wdf_end  = app_wdf_wren;

  always_ff @(posedge clk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      state        <= WAIT_CALIB;
      word_cnt     <= '0;
      req_cnt      <= '0;
      cap_cnt      <= '0;
      app_addr     <= ADDR_W'(BASE_ADDR);
      app_wdf_data <= '0;
      app_en       <= 1'b0;
      app_wdf_wren <= 1'b0;
      busy_write   <= 1'b0;
      end_of_write <= 1'b0;
    end else begin
      case (state)
        WAIT_CALIB: begin
          if (init_calib_complete) begin
            state      <= FILL;
            busy_write <= 1'b1;
          end
        end
        FILL: begin
          if (fifo_rd_en) req_cnt <= req_cnt + CNT_W'(1);
          if (fifo_valid && (cap_cnt < need_c)) begin
            app_wdf_data[cap_cnt*PIXEL_W +: PIXEL_W] <= fifo_dout;
            cap_cnt <= cap_cnt + CNT_W'(1);
            if (cap_cnt == need_c - CNT_W'(1)) begin
              state        <= ISSUE;
              app_en       <= 1'b1;
              app_wdf_wren <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (app_rdy)     app_en       <= 1'b0;
          if (app_wdf_rdy) app_wdf_wren <= 1'b0;
          if (cmd_ok_c && dat_ok_c) begin
            app_addr     <= app_addr + ADDR_W'(ADDR_STEP);
            word_cnt     <= word_cnt + WC_W'(1);
            app_wdf_data <= '0;
            req_cnt      <= '0;
            cap_cnt      <= '0;
            if (last_word_c) begin
              state        <= DONE;
              busy_write   <= 1'b0;
              end_of_write <= 1'b1;
            end else begin
              state <= FILL;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
